hub_mgu_seq: RTL and testbench
==============================

# hub_mgu_seq

Sequencer for the folded hybrid-unary (HUB) linear datapath used inside the MGU cell. It drives the datapath's `part`, `load`, `sel` and `clear` controls, so that one frame evaluates both MGU gate passes across all weight partitions. Each pass covers every partition and runs for a fixed bitstream depth. A start/done handshake connects it to the upstream frame scheduler, and a valid/ready handshake connects it to the downstream gate-combine stage.

## Interface
Parameters:
- `FOLD`, 8: number of weight/fmap partitions per gate pass; must be ≥ 1.
- `PWID`, `(FOLD < 2) ? 1 : $clog2(FOLD)`: width of `part`.
- `BDEP`, 256: bitstream cycles per partition; must be ≥ 1.
- `CWID`, `(BDEP < 2) ? 1 : $clog2(BDEP)`: width of the run-cycle counter.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `start`  in  1: request one frame; sampled only in IDLE.
- `abort`  in  1: synchronous cancel of the current frame.
- `out_ready`  in  1: downstream accepts the result.
- `busy`  out  1: frame in progress, including DONE.
- `load`  out  1: datapath loads partition `part`.
- `part`  out  PWID: partition index.
- `sel`  out  1: gate pass; 0 = forget gate, 1 = candidate.
- `clear`  out  1: datapath accumulator clear.
- `run`  out  1: datapath accumulates this cycle.
- `out_valid`  out  1: datapath output holds a finished frame.

## Operation
- States: IDLE, CLEAR, LOAD, RUN, DONE. Registers: `state`, `sel`, `part` (PWID bits), `cyc` (CWID bits).
- All outputs are Moore outputs decoded from registers.
- IDLE:
  - All outputs are 0.
  - `start=1` moves to CLEAR with `sel=0` and `part=0`.
- CLEAR: `clear=1` for exactly 1 cycle, then LOAD.
- LOAD: `load=1` for 1 cycle with the current `part`, then RUN with `cyc=0`.
- RUN:
  - `run=1`; `cyc` increments each cycle.
  - When `cyc==BDEP-1`: if `part<FOLD-1`, then `part++` and go to LOAD.
  - Otherwise, if `sel==0`, then `sel=1`, `part=0` and go to CLEAR.
  - Otherwise go to DONE.
- DONE:
  - `out_valid=1`; `sel` stays 1 and `part` stays FOLD-1.
  - On `out_ready=1`, go to IDLE and return `sel`, `part` and `cyc` to 0.
- `busy=1` in every state except IDLE.
- `abort=1` in any non-IDLE state:
  - Next state is IDLE with `sel`, `part` and `cyc` at 0.
  - `out_valid` never asserts for that frame.
  - `abort` has priority over every other transition, including a DONE handshake in the same cycle.
- `start` outside IDLE is ignored and is not queued. `start` in the cycle DONE→IDLE is also ignored, so it must be held or re-asserted.
- `part` never exceeds FOLD-1; `cyc` never exceeds BDEP-1; no counter wraps.
- Exactly one of `clear`, `load`, `run`, `out_valid` is high in any non-IDLE cycle.

## Timing
- Reset (`rst=1`, asynchronous): state IDLE, all counters 0, every output 0. Release is synchronous to `clk`.
- `start` sampled high at edge 0 gives CLEAR in cycle 1 and LOAD (part 0) in cycle 2.
- Cycles per gate pass: G = 1 + FOLD·(1+BDEP). Frame latency: `out_valid` first high in cycle 2G+1 after the accepting edge.
- `out_valid` stays high until the edge where `out_ready=1`; IDLE follows on the next cycle.
- Fixed pattern inside each pass: `clear`, then FOLD repetitions of (`load` plus BDEP `run` cycles).
- `sel` changes only on the RUN→CLEAR transition and on the return to IDLE. `part` changes only on RUN→LOAD and at pass or frame start.
- `rst` asserted mid-frame forces IDLE immediately and asynchronously; no `out_valid` is produced.

## Test plan
- Reset values: hold `rst`, drive `start=1` → all outputs 0; after release, `busy` rises 1 cycle after `start` is sampled.
- Nominal frame, FOLD=4, BDEP=8:
  - G=37 per pass; `out_valid` rises in cycle 75 with `out_ready=1`, and `busy` falls in cycle 76.
  - Counts: `load`=8, `run`=64, `clear`=2.
  - `part` sequence per pass is 0,1,2,3; `sel` goes 0→1 after cycle 37.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE → `out_valid` and `busy` stay high and the controls stay 0; `out_ready=1` → IDLE on the next cycle.
- Abort: pulse `abort` during RUN of part 2, sel=1 → IDLE next cycle and `out_valid` never rises; also pulse `abort` together with `out_ready` in DONE → IDLE, handshake not counted as a delivered frame.
- Edge params FOLD=1, BDEP=1: G=3; sequence CLEAR, LOAD, RUN, CLEAR, LOAD, RUN, DONE; `part` stays 0; `out_valid` in cycle 7.
- Ignored start and reset mid-frame:
  - `start` pulses in cycles 5 and 75 (DONE) → no second frame starts.
  - Async `rst` in cycle 20 → outputs 0 before the next edge.
  - After release, a fresh `start` gives full 2G+1 latency.

Source files
------------

// File: rtl/hub_mgu_seq.sv
// Control sequencer for the folded HUB linear datapath of the MGU cell.
// Walks clear/load/run over all partitions for both gate passes, then holds DONE.
module hub_mgu_seq #(
    parameter int FOLD = 8,
    parameter int PWID = (FOLD < 2) ? 1 : $clog2(FOLD),
    parameter int BDEP = 256,
    parameter int CWID = (BDEP < 2) ? 1 : $clog2(BDEP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            out_ready,
    output logic            busy,
    output logic            load,
    output logic [PWID-1:0] part,
    output logic            sel,
    output logic            clear,
    output logic            run,
    output logic            out_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [PWID-1:0] PART_LAST = PWID'(FOLD - 1);
    localparam logic [CWID-1:0] CYC_LAST  = CWID'(BDEP - 1);

    state_t            state, state_d;
    logic              sel_q, sel_d;
    logic [PWID-1:0]   part_q, part_d;
    logic [CWID-1:0]   cyc_q, cyc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel_q  <= 1'b0;
            part_q <= '0;
            cyc_q  <= '0;
        end else begin
            state  <= state_d;
            sel_q  <= sel_d;
            part_q <= part_d;
            cyc_q  <= cyc_d;
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        part_d  = part_q;
        cyc_d   = cyc_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    sel_d   = 1'b0;
                    part_d  = '0;
                end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_RUN;
                cyc_d   = '0;
            end
            S_RUN: begin
                if (cyc_q == CYC_LAST) begin
                    // cyc parks at 0 between partitions so it never wraps
                    cyc_d = '0;
                    if (part_q != PART_LAST) begin
                        part_d  = part_q + 1'b1;
                        state_d = S_LOAD;
                    end else if (!sel_q) begin
                        sel_d   = 1'b1;
                        part_d  = '0;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    sel_d   = 1'b0;
                    part_d  = '0;
                    cyc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort outranks every transition, including the DONE handshake
        if (abort && state != S_IDLE) begin
            state_d = S_IDLE;
            sel_d   = 1'b0;
            part_d  = '0;
            cyc_d   = '0;
        end
    end

    assign busy      = (state != S_IDLE);
    assign clear     = (state == S_CLEAR);
    assign load      = (state == S_LOAD);
    assign run       = (state == S_RUN);
    assign out_valid = (state == S_DONE);
    assign sel       = sel_q;
    assign part      = part_q;

endmodule

// File: tb/tb_hub_mgu_seq.sv
// Self-checking bench for hub_mgu_seq: a FOLD=4/BDEP=8 instance and a FOLD=1/BDEP=1 instance,
// compared cycle by cycle against a schedule built directly from the pass/partition rules.
module tb_hub_mgu_seq;

    typedef logic [7:0] vec_t; // {busy, clear, load, run, out_valid, sel, part[1:0]}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, out_ready;
    logic       busy, load, sel, clear, run, out_valid;
    logic [1:0] part;
    logic       start1, abort1, ready1;
    logic       busy1, load1, sel1, clear1, run1, out_valid1;
    logic [0:0] part1;

    hub_mgu_seq #(.FOLD(4), .BDEP(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
        .busy(busy), .load(load), .part(part), .sel(sel), .clear(clear),
        .run(run), .out_valid(out_valid)
    );

    hub_mgu_seq #(.FOLD(1), .BDEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .out_ready(ready1),
        .busy(busy1), .load(load1), .part(part1), .sel(sel1), .clear(clear1),
        .run(run1), .out_valid(out_valid1)
    );

    int   vectors = 0;
    int   errors  = 0;
    vec_t exp_q[$];

    localparam int GA = 1 + 4 * (1 + 8);

    function automatic vec_t obs_a();
        return {busy, clear, load, run, out_valid, sel, part};
    endfunction

    function automatic vec_t obs_b();
        return {busy1, clear1, load1, run1, out_valid1, sel1, 1'b0, part1};
    endfunction

    function automatic vec_t done_vec(int fold);
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'(fold - 1)};
    endfunction

    // Expected per-cycle outputs from CLEAR of pass 0 up to the last RUN of pass 1.
    task automatic build(int fold, int bdep);
        logic s;
        exp_q.delete();
        for (int g = 0; g < 2; g++) begin
            s = (g == 1);
            exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, s, 2'b00});
            for (int p = 0; p < fold; p++) begin
                exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, s, 2'(p)});
                for (int c = 0; c < bdep; c++)
                    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s, 2'(p)});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start1 = 1'b1;
        abort = 1'b0; abort1 = 1'b0; out_ready = 1'b0; ready1 = 1'b0;
        repeat (3) step();
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL reset_a: got %b expected %b", obs_a(), 8'h00);
        end
        vectors++;
        if (obs_b() !== 8'h00) begin
            errors++; $display("FAIL reset_b: got %b expected %b", obs_b(), 8'h00);
        end
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        step();
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL idle_after_release: got %b expected %b", obs_a(), 8'h00);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (obs_a() !== 8'b1100_0000) begin
            errors++; $display("FAIL busy_rise: got %b expected %b", obs_a(), 8'b1100_0000);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL abort_in_clear: got %b expected %b", obs_a(), 8'h00);
        end
    endtask

    task automatic test_nominal();
        int nload = 0, nrun = 0, nclear = 0;
        build(4, 8);
        start = 1'b1;
        step();
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_a() !== exp_q[k]) begin
                errors++;
                $display("FAIL nominal_cycle%0d: got %b expected %b", k + 1, obs_a(), exp_q[k]);
            end
            nload += int'(load); nrun += int'(run); nclear += int'(clear);
            start = ($urandom_range(0, 5) == 0); // stray starts must be ignored
            step();
        end
        vectors++;
        if (obs_a() !== done_vec(4)) begin
            errors++; $display("FAIL nominal_done_c%0d: got %b expected %b", 2 * GA + 1, obs_a(), done_vec(4));
        end
        vectors++;
        if (nload !== 8) begin errors++; $display("FAIL load_count: got %0d expected 8", nload); end
        vectors++;
        if (nrun !== 64) begin errors++; $display("FAIL run_count: got %0d expected 64", nrun); end
        vectors++;
        if (nclear !== 2) begin errors++; $display("FAIL clear_count: got %0d expected 2", nclear); end
        out_ready = 1'b1; start = 1'b1; // start on the DONE->IDLE edge is dropped
        step();
        out_ready = 1'b0; start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_a() !== 8'h00) begin
                errors++; $display("FAIL nominal_idle%0d: got %b expected %b", k, obs_a(), 8'h00);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int stall;
        stall = 10 + int'($urandom_range(0, 3));
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2 * GA) step();
        for (int k = 0; k < stall; k++) begin
            vectors++;
            if (obs_a() !== done_vec(4)) begin
                errors++; $display("FAIL stall%0d: got %b expected %b", k, obs_a(), done_vec(4));
            end
            start = $urandom_range(0, 1) == 1;
            step();
        end
        start = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL stall_release: got %b expected %b", obs_a(), 8'h00);
        end
    endtask

    task automatic test_abort();
        int c;
        bit seen_ov;
        build(4, 8);
        c = GA + 1 + 1 + 2 * 9 + 1 + int'($urandom_range(0, 7)); // a RUN cycle of part 2, sel 1
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (c - 1) step();
        vectors++;
        if (obs_a() !== exp_q[c - 1]) begin
            errors++; $display("FAIL abort_pre_c%0d: got %b expected %b", c, obs_a(), exp_q[c - 1]);
        end
        abort = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL abort_run: got %b expected %b", obs_a(), 8'h00);
        end
        seen_ov = 1'b0;
        repeat (2 * GA + 4) begin
            seen_ov |= out_valid;
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (seen_ov !== 1'b0) begin
            errors++; $display("FAIL abort_no_valid: got %b expected 0", seen_ov);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2 * GA) step();
        vectors++;
        if (obs_a() !== done_vec(4)) begin
            errors++; $display("FAIL abort_done_pre: got %b expected %b", obs_a(), done_vec(4));
        end
        abort = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0; out_ready = 1'b0;
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL abort_done: got %b expected %b", obs_a(), 8'h00);
        end
    endtask

    task automatic test_edge_params();
        int wait_n;
        build(1, 1);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_b() !== exp_q[k]) begin
                errors++; $display("FAIL edge_cycle%0d: got %b expected %b", k + 1, obs_b(), exp_q[k]);
            end
            step();
        end
        wait_n = int'($urandom_range(0, 4));
        for (int k = 0; k <= wait_n; k++) begin
            vectors++;
            if (obs_b() !== done_vec(1)) begin
                errors++; $display("FAIL edge_done_c%0d: got %b expected %b", 7 + k, obs_b(), done_vec(1));
            end
            ready1 = (k == wait_n);
            step();
        end
        ready1 = 1'b0;
        vectors++;
        if (obs_b() !== 8'h00) begin
            errors++; $display("FAIL edge_idle: got %b expected %b", obs_b(), 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        build(4, 8);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        vectors++;
        if (obs_a() !== exp_q[19]) begin
            errors++; $display("FAIL mid_pre_rst: got %b expected %b", obs_a(), exp_q[19]);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs_a() !== 8'h00) begin
            errors++; $display("FAIL async_rst: got %b expected %b", obs_a(), 8'h00);
        end
        step();
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            vectors++;
            if (obs_a() !== exp_q[k]) begin
                errors++; $display("FAIL post_rst_cycle%0d: got %b expected %b", k + 1, obs_a(), exp_q[k]);
            end
            step();
        end
        vectors++;
        if (obs_a() !== done_vec(4)) begin
            errors++; $display("FAIL post_rst_done: got %b expected %b", obs_a(), done_vec(4));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_abort();
        test_edge_params();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
